// File: rtl/alu_pkg.sv
// Shared constants for the ALU and the sequential multiplier.
// ALU opcodes, operand width and multiplier FSM encoding.
package alu_pkg;

    localparam int WIDTH = 32;

    // op[2] doubles as carry-in and invert-b
    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_32bit.sv
// 32-bit ripple ALU: AND, OR, ADD, SUB.
// op[2] inverts b and feeds the carry chain's carry-in.
module alu_32bit
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             c_out
);

    logic [WIDTH-1:0] sum;

    // ripple carry chain, one full adder per bit
    always_comb begin
        logic c;
        logic bb;
        c   = op[2];
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bb     = b[i] ^ op[2];
            sum[i] = a[i] ^ bb ^ c;
            c      = (a[i] & bb) | (a[i] & c) | (bb & c);
        end
        c_out = c;
    end

    // result select on the low opcode bits
    always_comb begin
        r = sum;
        unique case (op[1:0])
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            default: r = sum;
        endcase
    end

endmodule

// File: rtl/mult_32bit_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier.
// One ALU add per cycle, 32 iterations, start/busy/done handshake.
module mult_32bit_seq
    import alu_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [1:0]       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic [WIDTH-1:0] sum;
    logic             cy;

    alu_32bit u_alu (
        .a     (hi),
        .b     (mcand),
        .op    (ALU_OP_ADD),
        .r     (alu_r),
        .c_out (alu_c)
    );

    // add multiplicand only when the current multiplier bit is set
    always_comb begin
        sum = hi;
        cy  = 1'b0;
        if (lo[0]) begin
            sum = alu_r;
            cy  = alu_c;
        end
    end

    // control FSM plus shift registers; carry becomes new hi MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    hi  <= {cy, sum[WIDTH-1:1]};
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state == ST_CALC) || (state == ST_DONE);
    assign done    = (state == ST_DONE);
    assign product = {hi, lo};

endmodule

// File: tb/tb_mult_32bit_seq.sv
// Directed testbench for mult_32bit_seq.
// Inputs driven on falling edge, outputs sampled on falling edge.
module tb_mult_32bit_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_cmp;
    int n_err;

    mult_32bit_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands and start before edge E0; return just after E0.
    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Watch 40 cycles after E0; report first done cycle, product, pulses.
    task automatic wait_done(output int cyc, output logic [63:0] p,
                             output int pulses, output logic busy1);
        cyc    = -1;
        p      = '0;
        pulses = 0;
        busy1  = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                busy1 = busy;
                a     = 32'h1234_5678;
                b     = 32'h9ABC_DEF0;
            end
            if (done) begin
                pulses++;
                if (cyc < 0) begin
                    cyc = n;
                    p   = product;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done got %b want 0", done);
        end
        n_cmp++;
        if (product !== 64'h0) begin
            n_err++;
            $display("FAIL reset_product got %h want 0", product);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_nostart got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mul(input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp, input string name);
        int          cyc;
        int          pulses;
        logic [63:0] p;
        logic        busy1;
        launch(x, y);
        wait_done(cyc, p, pulses, busy1);
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL %s_busy1 got %b want 1", name, busy1);
        end
        n_cmp++;
        if (cyc != 33) begin
            n_err++;
            $display("FAIL %s_done_cycle got %0d want 33", name, cyc);
        end
        n_cmp++;
        if (p !== exp) begin
            n_err++;
            $display("FAIL %s_product got %h want %h", name, p, exp);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL %s_pulses got %0d want 1", name, pulses);
        end
        n_cmp++;
        if (product !== exp) begin
            n_err++;
            $display("FAIL %s_hold got %h want %h", name, product, exp);
        end
    endtask

    task automatic test_busy_start();
        int          cyc;
        int          pulses;
        logic [63:0] p;
        logic        busy1;
        cyc    = -1;
        pulses = 0;
        p      = '0;
        launch(32'd7, 32'd6);
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (cyc < 0) begin
                    cyc = n;
                    p   = product;
                end
            end
            if (n == 5 || n == 33 || n == 34) begin
                a     = 32'd9;
                b     = 32'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        n_cmp++;
        if (cyc != 33) begin
            n_err++;
            $display("FAIL ignore_done_cycle got %0d want 33", cyc);
        end
        n_cmp++;
        if (p !== 64'd42) begin
            n_err++;
            $display("FAIL ignore_product got %h want %h", p, 64'd42);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL ignore_pulses got %0d want 1", pulses);
        end
        @(posedge clk);
        wait_done(cyc, p, pulses, busy1);
        n_cmp++;
        if (cyc != 33) begin
            n_err++;
            $display("FAIL b2b_done_cycle got %0d want 33", cyc);
        end
        n_cmp++;
        if (p !== 64'd81) begin
            n_err++;
            $display("FAIL b2b_product got %h want %h", p, 64'd81);
        end
    endtask

    task automatic test_mid_reset();
        int pulses;
        pulses = 0;
        launch(32'd100, 32'd100);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) pulses++;
            if (n == 10) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_busy got %b want 0", busy);
        end
        n_cmp++;
        if (product !== 64'h0) begin
            n_err++;
            $display("FAIL midrst_product got %h want 0", product);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL midrst_nodone got %0d pulses want 0", pulses);
        end
        test_mul(32'd7, 32'd6, 64'd42, "restart");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, "small");
        test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 64'hFFFF_FFFE_0000_0001, "allones");
        test_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "msb");
        test_mul(32'd0, 32'hDEAD_BEEF, 64'h0, "zero");
        test_mul(32'h0001_0000, 32'h0001_0000,
                 64'h0000_0001_0000_0000, "pow2");
        test_busy_start();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
